branch_cc_unit: RTL and testbench

- ID-stage control-transfer resolver. It sits beside the control unit and consumes its ID_B_instr, ID_Call_instr and ID_29_a outputs, plus the EX-stage ALU flags and modifyCC.
- Holds the integer condition-code register (icc) and evaluates the Bicc condition.
- Produces the nPC source select and target address.
- Sequences the delayed-branch slot, including SPARC annul semantics. Its ds_nop output drives the S select of the control-signal nop mux.

---
 rtl/branch_cc_unit.sv | 211 +++++++++++++++++++++
 tb/tb_branch_cc_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cc_unit.sv
// ---------------------------------------------------------------------------------------------
// branch_cc_unit
//
// ID-stage control-transfer resolver. It holds the integer condition codes (icc), evaluates the
// Bicc condition for the instruction in ID, and selects the nPC source and target. It also
// sequences the delayed-branch slot, including SPARC annul semantics.
//
// Optional build macro: CC_FORWARD_EN
//   When defined, an EX-stage instruction that writes icc forwards its flags straight into the
//   Bicc evaluation. This lets a compare be followed immediately by a dependent branch.
//   When undefined, the branch sees only the registered icc.
//
// Parameters
//   ADDR_W         width of instruction addresses (PC/nPC)
//
// Ports
//   Clk            clock; all state updates on the rising edge
//   R              synchronous, active-high reset
//   ID_instr       instruction word from the IF/ID register
//   ID_pc          PC of the instruction in ID
//   ID_B_instr     control unit: Bicc in ID
//   ID_Call_instr  control unit: CALL in ID
//   ID_29_a        control unit: annul bit of the branch
//   EX_jmpl_instr  JMPL in EX
//   EX_alu_out     JMPL target (ALU result, low bits)
//   EX_modifyCC    instruction in EX writes icc
//   EX_alu_flags   {N,Z,V,C} from the ALU
//   stall          hazard stall; the IF/ID register is frozen this cycle
//   icc            registered {N,Z,V,C}
//   branch_taken   combinational: condition true for the Bicc in ID
//   pc_src         00 sequential, 01 branch/call target, 10 JMPL target
//   target_addr    address loaded into nPC when pc_src != 00
//   ds_nop         registered: squash the delay-slot instruction now in ID
//   state          FSM state (00 SEQ, 01 DSLOT, 10 DANNUL), for debug
// ---------------------------------------------------------------------------------------------

module branch_cc_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              R,
    input  logic [31:0]       ID_instr,
    input  logic [ADDR_W-1:0] ID_pc,
    input  logic              ID_B_instr,
    input  logic              ID_Call_instr,
    input  logic              ID_29_a,
    input  logic              EX_jmpl_instr,
    input  logic [ADDR_W-1:0] EX_alu_out,
    input  logic              EX_modifyCC,
    input  logic [3:0]        EX_alu_flags,
    input  logic              stall,
    output logic [3:0]        icc,
    output logic              branch_taken,
    output logic [1:0]        pc_src,
    output logic [ADDR_W-1:0] target_addr,
    output logic              ds_nop,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StSeq    = 2'b00,
        StDslot  = 2'b01,
        StDannul = 2'b10
    } state_e;

    state_e      r_state;
    logic        r_ds_nop;
    logic [3:0]  r_icc;

    logic [3:0]  w_cc;
    logic [3:0]  w_cond;
    logic        w_n;
    logic        w_z;
    logic        w_v;
    logic        w_c;
    logic        w_base;
    logic        w_taken;
    logic        w_cti;
    logic        w_annul;
    logic        w_redirect;
    logic [31:0] w_br_off;
    logic [31:0] w_call_off;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_call_target;
    logic [ADDR_W-1:0] w_cti_target;
    logic        w_unused;

    // -----------------------------------------------------------------------------------------
    // Condition-code register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (R) begin
            r_icc <= 4'b0000;
        end else if (EX_modifyCC) begin
            r_icc <= EX_alu_flags;
        end
    end

`ifdef CC_FORWARD_EN
    assign w_cc = EX_modifyCC ? EX_alu_flags : r_icc;
`else
    assign w_cc = r_icc;
`endif

    // -----------------------------------------------------------------------------------------
    // Bicc condition evaluation: cond[3] inverts the sense of the base test in cond[2:0]
    // -----------------------------------------------------------------------------------------
    assign w_cond = ID_instr[28:25];
    assign w_n    = w_cc[3];
    assign w_z    = w_cc[2];
    assign w_v    = w_cc[1];
    assign w_c    = w_cc[0];

    always_comb begin
        w_base = 1'b0;
        case (w_cond[2:0])
            3'b000:  w_base = 1'b0;
            3'b001:  w_base = w_z;
            3'b010:  w_base = w_z | (w_n ^ w_v);
            3'b011:  w_base = w_n ^ w_v;
            3'b100:  w_base = w_c | w_z;
            3'b101:  w_base = w_c;
            3'b110:  w_base = w_n;
            3'b111:  w_base = w_v;
            default: w_base = 1'b0;
        endcase
    end

    assign w_taken      = ID_B_instr & (w_base ^ w_cond[3]);
    assign branch_taken = w_taken;

    // -----------------------------------------------------------------------------------------
    // Target addresses; offsets are formed at 32 bits and wrap modulo 2^ADDR_W
    // -----------------------------------------------------------------------------------------
    assign w_br_off      = {{8{ID_instr[21]}}, ID_instr[21:0], 2'b00};
    assign w_call_off    = {ID_instr[29:0], 2'b00};
    assign w_br_target   = ID_pc + w_br_off[ADDR_W-1:0];
    assign w_call_target = ID_pc + w_call_off[ADDR_W-1:0];
    assign w_cti_target  = ID_Call_instr ? w_call_target : w_br_target;

    // op/op2 fields and the high offset bits are not needed here
    assign w_unused = ^{ID_instr[31:30], ID_instr[24:22], w_br_off, w_call_off};

    // -----------------------------------------------------------------------------------------
    // Redirect decision
    // -----------------------------------------------------------------------------------------
    assign w_cti = ID_B_instr | ID_Call_instr;

    // BA,a annuls even though taken; any untaken Bicc with a=1 annuls; CALL never annuls
    assign w_annul = ID_B_instr & ~ID_Call_instr & ID_29_a &
                     ((w_cond == 4'b1000) | ~w_taken);

    // A CTI sitting in the delay slot is ignored (DCTI couples unsupported)
    assign w_redirect = (r_state == StSeq) & ~stall &
                        (ID_Call_instr | (ID_B_instr & w_taken));

    always_comb begin
        pc_src      = 2'b00;
        target_addr = '0;
        if (EX_jmpl_instr) begin
            pc_src      = 2'b10;
            target_addr = EX_alu_out;
        end else if (w_redirect) begin
            pc_src      = 2'b01;
            target_addr = w_cti_target;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Delay-slot FSM. r_ds_nop is registered as (next state == DANNUL), so it is high exactly
    // while the squashed slot instruction sits in ID; holding state on stall also holds it.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (R) begin
            r_state  <= StSeq;
            r_ds_nop <= 1'b0;
        end else begin
            case (r_state)
                StSeq: begin
                    if (!stall && w_cti) begin
                        if (w_annul) begin
                            r_state  <= StDannul;
                            r_ds_nop <= 1'b1;
                        end else begin
                            r_state  <= StDslot;
                            r_ds_nop <= 1'b0;
                        end
                    end else begin
                        r_state  <= StSeq;
                        r_ds_nop <= 1'b0;
                    end
                end
                StDslot, StDannul: begin
                    if (!stall) begin
                        r_state  <= StSeq;
                        r_ds_nop <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StSeq;
                    r_ds_nop <= 1'b0;
                end
            endcase
        end
    end

    assign icc    = r_icc;
    assign ds_nop = r_ds_nop;
    assign state  = r_state;

endmodule

// File: tb/tb_branch_cc_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_branch_cc_unit
//
// Directed self-checking bench for branch_cc_unit (ADDR_W = 8). Inputs change 1 time unit
// after the rising edge; outputs are sampled a further 1-2 units later, well before the next
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------------------------

module tb_branch_cc_unit;

    localparam int unsigned ADDR_W = 8;

    logic              Clk;
    logic              R;
    logic [31:0]       ID_instr;
    logic [ADDR_W-1:0] ID_pc;
    logic              ID_B_instr;
    logic              ID_Call_instr;
    logic              ID_29_a;
    logic              EX_jmpl_instr;
    logic [ADDR_W-1:0] EX_alu_out;
    logic              EX_modifyCC;
    logic [3:0]        EX_alu_flags;
    logic              stall;
    logic [3:0]        icc;
    logic              branch_taken;
    logic [1:0]        pc_src;
    logic [ADDR_W-1:0] target_addr;
    logic              ds_nop;
    logic [1:0]        state;

    int n_checks;
    int n_fail;

    branch_cc_unit #(
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk          (Clk),
        .R            (R),
        .ID_instr     (ID_instr),
        .ID_pc        (ID_pc),
        .ID_B_instr   (ID_B_instr),
        .ID_Call_instr(ID_Call_instr),
        .ID_29_a      (ID_29_a),
        .EX_jmpl_instr(EX_jmpl_instr),
        .EX_alu_out   (EX_alu_out),
        .EX_modifyCC  (EX_modifyCC),
        .EX_alu_flags (EX_alu_flags),
        .stall        (stall),
        .icc          (icc),
        .branch_taken (branch_taken),
        .pc_src       (pc_src),
        .target_addr  (target_addr),
        .ds_nop       (ds_nop),
        .state        (state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] bicc(input logic a, input logic [3:0] cond,
                                         input logic [21:0] disp);
        return {2'b00, a, cond, 3'b010, disp};
    endfunction

    task automatic clear_cti();
        ID_B_instr    = 1'b0;
        ID_Call_instr = 1'b0;
        ID_29_a       = 1'b0;
        ID_instr      = 32'h0;
        EX_jmpl_instr = 1'b0;
        EX_alu_out    = '0;
    endtask

    logic [3:0] tbl_cond [16];
    logic       tbl_exp  [16];
    logic       fwd_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // icc = 1010: N=1 Z=0 V=1 C=0, so N^V=0
        tbl_cond = '{4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0111, 4'b1111,
                     4'b0101, 4'b1101, 4'b0100, 4'b1100, 4'b0001, 4'b1001, 4'b0000, 4'b1000};
        tbl_exp  = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1,    1'b0,
                     1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
`ifdef CC_FORWARD_EN
        fwd_exp = 1'b1;
`else
        fwd_exp = 1'b0;
`endif

        // Reset with busy inputs: reset must win over modifyCC and a CTI
        R             = 1'b1;
        ID_instr      = bicc(1'b1, 4'b1000, 22'd1);
        ID_pc         = 8'h33;
        ID_B_instr    = 1'b1;
        ID_Call_instr = 1'b0;
        ID_29_a       = 1'b1;
        EX_jmpl_instr = 1'b0;
        EX_alu_out    = 8'h55;
        EX_modifyCC   = 1'b1;
        EX_alu_flags  = 4'hF;
        stall         = 1'b0;
        tick();
        tick();
        check("reset_icc", 32'(icc), 32'h0);
        check("reset_state", 32'(state), 32'h0);
        check("reset_ds_nop", 32'(ds_nop), 32'h0);
        clear_cti();
        EX_modifyCC = 1'b0;
        #1;
        check("reset_pc_src", 32'(pc_src), 32'h0);

        // Load icc = 0100 (Z set)
        R            = 1'b0;
        EX_modifyCC  = 1'b1;
        EX_alu_flags = 4'b0100;
        tick();
        EX_modifyCC  = 1'b0;
        EX_alu_flags = 4'b1010;
        check("icc_load", 32'(icc), 32'h4);

        // BE taken, a=0: 0x10 + 3*4 = 0x1C
        ID_B_instr = 1'b1;
        ID_instr   = bicc(1'b0, 4'b0001, 22'd3);
        ID_pc      = 8'h10;
        #1;
        check("be_taken", 32'(branch_taken), 32'h1);
        check("be_pc_src", 32'(pc_src), 32'h1);
        check("be_target", 32'(target_addr), 32'h1C);
        tick();
        clear_cti();
        check("be_state", 32'(state), 32'h1);
        check("be_ds_nop", 32'(ds_nop), 32'h0);
        check("icc_hold", 32'(icc), 32'h4);
        tick();
        check("be_back_seq", 32'(state), 32'h0);

        // Untaken BNE,a annuls the slot
        ID_B_instr = 1'b1;
        ID_29_a    = 1'b1;
        ID_instr   = bicc(1'b1, 4'b1001, 22'd5);
        #1;
        check("bne_a_taken", 32'(branch_taken), 32'h0);
        check("bne_a_pc_src", 32'(pc_src), 32'h0);
        tick();
        check("bne_a_state", 32'(state), 32'h2);
        check("bne_a_ds_nop", 32'(ds_nop), 32'h1);
        // CTI in the slot is ignored
        ID_29_a  = 1'b0;
        ID_instr = bicc(1'b0, 4'b1000, 22'd2);
        #1;
        check("slot_cti_ignored", 32'(pc_src), 32'h0);
        tick();
        clear_cti();
        check("bne_a_back_seq", 32'(state), 32'h0);
        check("bne_a_ds_nop_clr", 32'(ds_nop), 32'h0);

        // BA,a with disp -1 under stall: 0x20 - 4 = 0x1C
        ID_B_instr = 1'b1;
        ID_29_a    = 1'b1;
        ID_instr   = bicc(1'b1, 4'b1000, 22'h3FFFFF);
        ID_pc      = 8'h20;
        stall      = 1'b1;
        #1;
        check("ba_a_stall_taken", 32'(branch_taken), 32'h1);
        check("ba_a_stall_pc_src", 32'(pc_src), 32'h0);
        tick();
        check("ba_a_stall_state1", 32'(state), 32'h0);
        tick();
        check("ba_a_stall_state2", 32'(state), 32'h0);
        stall = 1'b0;
        #1;
        check("ba_a_pc_src", 32'(pc_src), 32'h1);
        check("ba_a_target", 32'(target_addr), 32'h1C);
        tick();
        clear_cti();
        check("ba_a_state", 32'(state), 32'h2);
        check("ba_a_ds_nop", 32'(ds_nop), 32'h1);
        stall = 1'b1;
        tick();
        check("dannul_stall_state", 32'(state), 32'h2);
        check("dannul_stall_ds_nop", 32'(ds_nop), 32'h1);
        stall = 1'b0;
        tick();
        check("ba_a_back_seq", 32'(state), 32'h0);
        check("ba_a_ds_nop_clr", 32'(ds_nop), 32'h0);

        // CALL wrap: 0xF8 + 16 = 0x108 -> 0x08; then JMPL overrides in the same cycle
        ID_Call_instr = 1'b1;
        ID_instr      = {2'b01, 30'd4};
        ID_pc         = 8'hF8;
        #1;
        check("call_pc_src", 32'(pc_src), 32'h1);
        check("call_target", 32'(target_addr), 32'h08);
        EX_jmpl_instr = 1'b1;
        EX_alu_out    = 8'h40;
        #1;
        check("jmpl_pc_src", 32'(pc_src), 32'h2);
        check("jmpl_target", 32'(target_addr), 32'h40);
        tick();
        clear_cti();
        check("call_state", 32'(state), 32'h1);
        check("call_ds_nop", 32'(ds_nop), 32'h0);
        tick();
        check("call_back_seq", 32'(state), 32'h0);

        // Taken BE,a does not annul
        ID_B_instr = 1'b1;
        ID_29_a    = 1'b1;
        ID_instr   = bicc(1'b1, 4'b0001, 22'd1);
        ID_pc      = 8'h40;
        #1;
        check("be_a_pc_src", 32'(pc_src), 32'h1);
        check("be_a_target", 32'(target_addr), 32'h44);
        tick();
        clear_cti();
        check("be_a_state", 32'(state), 32'h1);
        check("be_a_ds_nop", 32'(ds_nop), 32'h0);
        tick();

        // Full condition table with icc = 1010, held in SEQ by stall
        EX_modifyCC  = 1'b1;
        EX_alu_flags = 4'b1010;
        tick();
        EX_modifyCC  = 1'b0;
        EX_alu_flags = 4'b0000;
        check("icc_1010", 32'(icc), 32'hA);
        stall      = 1'b1;
        ID_B_instr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ID_instr = bicc(1'b0, tbl_cond[i], 22'd0);
            #1;
            check($sformatf("cond_%b", tbl_cond[i]), 32'(branch_taken), 32'(tbl_exp[i]));
        end
        ID_B_instr = 1'b0;
        ID_instr   = bicc(1'b0, 4'b1000, 22'd0);
        #1;
        check("bt_gated_by_B", 32'(branch_taken), 32'h0);
        stall = 1'b0;
        clear_cti();
        tick();
        check("table_state_seq", 32'(state), 32'h0);

        // Forwarding: icc=0000 while EX writes 0100 and BE sits in ID
        EX_modifyCC  = 1'b1;
        EX_alu_flags = 4'b0000;
        tick();
        check("icc_zero", 32'(icc), 32'h0);
        EX_alu_flags = 4'b0100;
        ID_B_instr   = 1'b1;
        ID_instr     = bicc(1'b0, 4'b0001, 22'd3);
        ID_pc        = 8'h10;
        #1;
        check("fwd_taken", 32'(branch_taken), 32'(fwd_exp));
        check("fwd_pc_src", 32'(pc_src), fwd_exp ? 32'h1 : 32'h0);
        tick();
        EX_modifyCC = 1'b0;
        clear_cti();
        check("fwd_icc", 32'(icc), 32'h4);
        check("fwd_state", 32'(state), 32'h1);
        tick();

        // Reset mid-slot drops the pending annul
        ID_B_instr = 1'b1;
        ID_29_a    = 1'b1;
        ID_instr   = bicc(1'b1, 4'b1000, 22'd0);
        tick();
        clear_cti();
        check("pre_reset_state", 32'(state), 32'h2);
        check("pre_reset_ds_nop", 32'(ds_nop), 32'h1);
        R = 1'b1;
        tick();
        R = 1'b0;
        check("mid_reset_state", 32'(state), 32'h0);
        check("mid_reset_ds_nop", 32'(ds_nop), 32'h0);
        check("mid_reset_icc", 32'(icc), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
